// File: rtl/change_dispenser.sv
// change_dispenser: pays a latched balance out as coins, largest denomination first,
// one coin per hopper handshake, with ack timeout fault and residue reporting.
module change_dispenser #(
    parameter int NUM_COINS   = 3,
    parameter int TOTAL_BITS  = 31,
    parameter int COIN_VAL0   = 100,
    parameter int COIN_VAL1   = 500,
    parameter int COIN_VAL2   = 1000,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_return_req,
    input  logic [TOTAL_BITS-1:0] i_balance,
    input  logic                  i_coin_ack,
    output logic [NUM_COINS-1:0]  o_coin_req,
    output logic                  o_busy,
    output logic [TOTAL_BITS-1:0] o_balance,
    output logic [TOTAL_BITS-1:0] o_residue,
    output logic                  o_done,
    output logic                  o_fault
);
    localparam int IW = $clog2(NUM_COINS);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TOTAL_BITS-1:0] COIN_VAL [NUM_COINS] =
        '{TOTAL_BITS'(COIN_VAL0), TOTAL_BITS'(COIN_VAL1), TOTAL_BITS'(COIN_VAL2)};

    typedef enum logic [2:0] {IDLE, SELECT, DISPENSE, FINISH, FAULT} state_t;
    state_t state, state_nx;
    logic [IW-1:0] sel, cur;
    logic          found;
    logic [TW-1:0] timer;
    logic          timed_out;

    // ascending scan so the highest payable denomination wins
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_COINS; k++)
            if (COIN_VAL[k] <= o_balance) begin
                found = 1'b1;
                sel   = IW'(k);
            end
    end

    assign timed_out = timer == TW'(ACK_TIMEOUT - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = i_return_req ? SELECT : IDLE;
            SELECT:   state_nx = (found && !o_fault) ? DISPENSE : FINISH;
            DISPENSE: state_nx = i_coin_ack ? SELECT : timed_out ? FAULT : DISPENSE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            o_coin_req <= '0;
            o_balance  <= '0;
            o_residue  <= '0;
            o_fault    <= 1'b0;
            timer      <= '0;
            cur        <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (i_return_req) begin
                    o_balance <= i_balance;
                    o_residue <= '0;
                end
                SELECT: if (found && !o_fault) begin
                    o_coin_req <= NUM_COINS'(1) << sel;
                    cur        <= sel;
                    timer      <= '0;
                end else begin
                    o_residue <= o_balance;
                    o_balance <= '0;
                end
                DISPENSE: begin
                    timer <= timer + TW'(1);
                    if (i_coin_ack) begin
                        o_balance  <= o_balance - COIN_VAL[cur];
                        o_coin_req <= '0;
                    end else if (timed_out) begin
                        o_coin_req <= '0;
                        o_fault    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = state != IDLE;
    assign o_done = state == FINISH || state == FAULT;
endmodule
